// File: rtl/scan_mux.sv
// scan_mux: registered N-to-1 channel multiplexer.
// Manual select or auto-scan with per-channel dwell.
module scan_mux #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 2,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          sel_out,
  output logic                      valid,
  output logic                      wrap,
  output logic                      err
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [SEL_W:0]   NCH   = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] PLAST = SEL_W'(CHANNELS - 1);
  localparam logic [DW_W-1:0]  DLAST = DW_W'(DWELL - 1);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic [SEL_W-1:0] pick;
  logic [WIDTH-1:0] ch_val;
  logic             sel_ok;
  logic             ptr_last;
  logic             dwell_last;

  assign sel_ok     = {1'b0, sel_in} < NCH;
  assign ptr_last   = ptr_q == PLAST;
  assign dwell_last = dwell_q == DLAST;

  // Choose which channel index is sampled at this edge.
  always_comb begin
    pick = ptr_q;
    if (en && !mode && sel_ok) begin
      pick = sel_in;
    end
  end

  // Channel slice lookup; unmatched codes cannot occur since pick is in range.
  always_comb begin
    ch_val = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (pick == SEL_W'(k)) begin
        ch_val = data_in[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state: hold when disabled, manual select, or auto-scan stepping.
  always_comb begin
    ptr_d   = ptr_q;
    dwell_d = dwell_q;
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    unique case (1'b1)
      !en: begin
        ptr_d   = ptr_q;
        dwell_d = dwell_q;
      end
      en && !mode: begin
        data_d  = ch_val;
        sel_d   = pick;
        ptr_d   = pick;
        dwell_d = '0;
        valid_d = 1'b1;
        err_d   = !sel_ok;
      end
      en && mode: begin
        data_d  = ch_val;
        sel_d   = pick;
        valid_d = 1'b1;
        if (dwell_last) begin
          dwell_d = '0;
          ptr_d   = ptr_last ? '0 : ptr_q + SEL_W'(1);
          wrap_d  = ptr_last;
        end else begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs with immediate asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      dwell_q <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign data_out = data_q;
  assign sel_out  = sel_q;
  assign valid    = valid_q;
  assign wrap     = wrap_q;
  assign err      = err_q;

endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: scoreboard bench for scan_mux.
// Two instances: 4 channels and 3 channels.
module tb_scan_mux;

  localparam int W = 4;
  localparam int D = 2;

  typedef logic [7:0] exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        en, mode;
  logic [1:0]  sel;
  logic [15:0] din;
  logic [3:0]  dout;
  logic [1:0]  sout;
  logic        valid, wrap, err;

  logic        en3, mode3;
  logic [1:0]  sel3;
  logic [11:0] din3;
  logic [3:0]  dout3;
  logic [1:0]  sout3;
  logic        valid3, wrap3, err3;

  scan_mux #(.WIDTH(4), .CHANNELS(4), .DWELL(2)) u4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .sel_in(sel), .data_in(din), .data_out(dout),
    .sel_out(sout), .valid(valid), .wrap(wrap), .err(err)
  );

  scan_mux #(.WIDTH(4), .CHANNELS(3), .DWELL(2)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .mode(mode3),
    .sel_in(sel3), .data_in(din3), .data_out(dout3),
    .sel_out(sout3), .valid(valid3), .wrap(wrap3), .err(err3)
  );

  int total = 0;
  int bad = 0;
  exp_t q4[$];
  exp_t q3[$];
  int p4 = 0;
  int p3 = 0;
  exp_t last4 = '0;
  exp_t last3 = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  // Scan position p counts enabled auto cycles within one frame.
  function automatic exp_t model(input int ch, input bit m, input int s,
                                 input logic [15:0] dv, inout int p);
    int c;
    bit w;
    bit e;
    w = 1'b0;
    e = 1'b0;
    if (!m) begin
      if (s < ch) c = s;
      else begin
        c = p / D;
        e = 1'b1;
      end
      p = c * D;
    end else begin
      c = p / D;
      w = (p == ch * D - 1);
      p = (p + 1) % (ch * D);
    end
    return {dv[c*W +: W], 2'(c), w, e};
  endfunction

  task automatic step(input bit e, input bit m, input logic [1:0] s,
                      input logic [15:0] d,
                      input bit e_3, input bit m_3, input logic [1:0] s_3,
                      input logic [11:0] d_3);
    exp_t x;
    en = e; mode = m; sel = s; din = d;
    en3 = e_3; mode3 = m_3; sel3 = s_3; din3 = d_3;
    if (e) begin
      x = model(4, m, int'(s), d, p4);
      q4.push_back(x);
      last4 = x;
    end
    if (e_3) begin
      x = model(3, m_3, int'(s_3), {4'h0, d_3}, p3);
      q3.push_back(x);
      last3 = x;
    end
    @(posedge clk);
    #1;
    if (e) check("valid4", {31'd0, valid}, 32'd1);
    else begin
      check("hold4_flags", {29'd0, valid, wrap, err}, 32'd0);
      check("hold4_data", {26'd0, dout, sout}, {26'd0, last4[7:2]});
    end
    if (e_3) check("valid3", {31'd0, valid3}, 32'd1);
    else check("hold3_flags", {29'd0, valid3, wrap3, err3}, 32'd0);
  endtask

  task automatic s4(input bit e, input bit m, input logic [1:0] s,
                    input logic [15:0] d);
    step(e, m, s, d, 1'b0, 1'b0, 2'd0, 12'h0);
  endtask

  task automatic check_zero(input string name);
    check({name, "_4"}, {21'd0, dout, sout, valid, wrap, err}, 32'd0);
    check({name, "_3"}, {21'd0, dout3, sout3, valid3, wrap3, err3}, 32'd0);
  endtask

  // Asynchronous reset applied between edges, held across one edge.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    q4.delete();
    q3.delete();
    p4 = 0;
    p3 = 0;
    last4 = '0;
    last3 = '0;
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: pop expected response whenever an instance presents valid.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        if (q4.size() == 0) check("q4_empty", 32'd1, 32'd0);
        else check("mon4", {24'd0, dout, sout, wrap, err},
                   {24'd0, q4.pop_front()});
      end
      if (valid3) begin
        if (q3.size() == 0) check("q3_empty", 32'd1, 32'd0);
        else check("mon3", {24'd0, dout3, sout3, wrap3, err3},
                   {24'd0, q3.pop_front()});
      end
    end
  end

  localparam logic [15:0] ABCD = 16'hDCBA;

  initial begin
    en = 0; mode = 0; sel = 0; din = ABCD;
    en3 = 0; mode3 = 0; sel3 = 0; din3 = 12'hCBA;
    #1;
    check_zero("por");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    // reset during activity, then idle with en=0
    repeat (3) s4(1, 1, 2'd0, ABCD);
    mid_reset();
    repeat (2) s4(0, 1, 2'd0, ABCD);
    // manual select
    s4(1, 0, 2'd2, ABCD);
    check("man_c", {28'd0, dout}, 32'hC);
    // auto from reset, 10 edges
    mid_reset();
    for (int i = 0; i < 10; i++) s4(1, 1, 2'd0, ABCD);
    // pause after first B
    mid_reset();
    repeat (3) s4(1, 1, 2'd0, ABCD);
    repeat (3) s4(0, 1, 2'd0, ABCD);
    check("pause_b", {28'd0, dout}, 32'hB);
    repeat (3) s4(1, 1, 2'd0, ABCD);
    // 3-channel out-of-range select
    step(0, 0, 2'd0, ABCD, 1, 0, 2'd1, 12'hCBA);
    step(0, 0, 2'd0, ABCD, 1, 0, 2'd3, 12'hCBA);
    check("ch3_err", {25'd0, dout3, sout3, err3}, {25'd0, 4'hB, 2'd1, 1'b1});
    // reset while showing C, then restart
    mid_reset();
    repeat (5) s4(1, 1, 2'd0, ABCD);
    check("show_c", {28'd0, dout}, 32'hC);
    mid_reset();
    repeat (3) s4(1, 1, 2'd0, ABCD);
    check("restart_b", {28'd0, dout}, 32'hB);
    // random traffic on both instances
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)), 16'($urandom),
           $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)), 12'($urandom));
    end
    s4(0, 0, 2'd0, ABCD);
    @(negedge clk);
    #1;
    check("q4_drain", q4.size(), 32'd0);
    check("q3_drain", q3.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
